single_port_ram: RTL and testbench
==================================

SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, address bus width in bits.
REQ-002 Parameter DATA_WIDTH, default 16, word width in bits.
REQ-003 Parameter DEPTH, default 16, number of words; legal range 1..2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 addr  input  ADDR_WIDTH  word address for the current cycle.
REQ-007 data  inout  DATA_WIDTH  bidirectional data bus; write data in, read data out.
REQ-008 cs  input  1  chip select, active-high; when low the block SHALL neither write, read nor drive data.
REQ-009 we  input  1  write enable, active-high.
REQ-010 oe  input  1  output enable, active-high.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_WIDTH bits.
REQ-012 Write: on a rising clk edge with rst=0, cs=1 and we=1, mem[addr] SHALL take the value on data.
REQ-013 Read: on a rising clk edge with rst=0, cs=1 and we=0, the internal read register SHALL load mem[addr]; read latency is one cycle.
REQ-014 The read register SHALL hold its value in any cycle without a read.
REQ-015 The block SHALL drive data with the read register only while cs=1, oe=1 and we=0; otherwise data SHALL be high-Z.
REQ-016 Output-enable decode SHALL be combinational; tri-state turn-on and turn-off SHALL follow cs/we/oe in the same cycle.
REQ-017 cs=1, we=1, oe=1: the write SHALL occur and data SHALL stay high-Z, so the bus is never contended.
REQ-018 addr >= DEPTH: writes SHALL be ignored; reads SHALL load all-zero into the read register.
REQ-019 Write then read of the same address in consecutive cycles SHALL return the newly written word.
REQ-020 Data SHALL be stored and returned unmodified, at full DATA_WIDTH, with no truncation or extension.

Reset
REQ-021 With rst=1 at a rising clk edge, the read register SHALL clear to 0.
REQ-022 rst SHALL take priority over cs/we; a write coinciding with reset SHALL be discarded.
REQ-023 The tri-state decode SHALL remain active during reset; data driven during reset carries the cleared read register (0).
REQ-024 Reset asserted mid-sequence SHALL abort only the operation in its own cycle; the next cycle after rst deasserts SHALL operate normally.

Configuration
REQ-025 Macro SINGLE_PORT_RAM_INIT_CLEAR_EN defined: a reset edge SHALL also clear all DEPTH memory words to 0 in that same cycle.
REQ-026 Macro undefined: reset SHALL clear only the read register; memory contents SHALL be retained across reset.

Verification
REQ-027 Defaults; write addr 0..15 with words 0x3524, 0x5E81, ..., one per cycle (cs=1, we=1, oe=0), then read 0..15 (cs=1, we=0, oe=1) -> data returns each written word one cycle after its address is applied.
REQ-028 cs=0, we=1, addr=3, data=0xFFFF; then read addr 3 -> original word at addr 3, unchanged; data high-Z while cs=0.
REQ-029 cs=1, we=0, oe=0 -> data high-Z; raise oe to 1 -> read-register value driven in that same cycle.
REQ-030 Write 0xA5A5 to addr 5 with oe=1 -> data high-Z during the write; next cycle, read addr 5 -> 0xA5A5.
REQ-031 DEPTH=12: write 0x1234 to addr 13, then read addr 13 -> 0x0000; words at addr 0..11 unchanged.
REQ-032 Write 0xBEEF to addr 7, pulse rst for one cycle, read addr 7 -> 0x0000 with SINGLE_PORT_RAM_INIT_CLEAR_EN, 0xBEEF without; read register reads 0 immediately after reset in both builds.

Source files
------------

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM with a bidirectional data bus and a registered read port.
// Optional build macro SINGLE_PORT_RAM_INIT_CLEAR_EN: reset also clears every memory word.
module single_port_ram #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  logic [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drive_en;

    assign in_range = (32'(addr) < DEPTH);
    assign wr_en    = cs && we && in_range;
    assign rd_en    = cs && !we;
    // Never drive while writing, so the bus cannot be contended even with oe high.
    assign drive_en = cs && oe && !we;

    assign data = drive_en ? rd_q : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef SINGLE_PORT_RAM_INIT_CLEAR_EN
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
`endif
        end else if (wr_en) begin
            mem[IDX_W'(addr)] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= in_range ? mem[IDX_W'(addr)] : '0;
        end
    end

endmodule

// File: tb/tb_single_port_ram.sv
// Directed bench for single_port_ram: default-size instance plus a DEPTH=12 instance.
module tb_single_port_ram;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0]  addr0 = '0;
    logic        cs0 = 1'b0, we0 = 1'b0, oe0 = 1'b0, den0 = 1'b0;
    logic [15:0] drv0 = '0;
    wire  [15:0] bus0;

    logic [3:0]  addr1 = '0;
    logic        cs1 = 1'b0, we1 = 1'b0, oe1 = 1'b0, den1 = 1'b0;
    logic [15:0] drv1 = '0;
    wire  [15:0] bus1;

    // Undriven bus reads as all-ones through the pullups.
    pullup (bus0[0]);  pullup (bus0[1]);  pullup (bus0[2]);  pullup (bus0[3]);
    pullup (bus0[4]);  pullup (bus0[5]);  pullup (bus0[6]);  pullup (bus0[7]);
    pullup (bus0[8]);  pullup (bus0[9]);  pullup (bus0[10]); pullup (bus0[11]);
    pullup (bus0[12]); pullup (bus0[13]); pullup (bus0[14]); pullup (bus0[15]);

    assign bus0 = den0 ? drv0 : 'z;
    assign bus1 = den1 ? drv1 : 'z;

    single_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16)) dut0 (
        .clk(clk), .rst(rst), .addr(addr0), .data(bus0), .cs(cs0), .we(we0), .oe(oe0)
    );

    single_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12)) dut1 (
        .clk(clk), .rst(rst), .addr(addr1), .data(bus1), .cs(cs1), .we(we1), .oe(oe1)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] HIZ = 16'hFFFF;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] model0 [16];
    logic [15:0] model1 [12];
    logic [15:0] wtab [16] = '{16'h3524, 16'h5E81, 16'hD609, 16'h5663,
                               16'h7B0D, 16'h998D, 16'h8465, 16'h5212,
                               16'hE301, 16'hCD0D, 16'hF176, 16'hCD3D,
                               16'h57ED, 16'hF78C, 16'hE9F9, 16'h24C6};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset cycle with a read pending: register clears and is driven as zero.
        rst = 1'b1; cs0 = 1'b1; we0 = 1'b0; oe0 = 1'b1; addr0 = 4'd0;
        step();
        check("reset_drive", bus0, 16'h0000);
        rst = 1'b0; cs0 = 1'b0;
        #1;
        check("cs_low_hiz", bus0, HIZ);

        // Fill default instance.
        den0 = 1'b1; cs0 = 1'b1; we0 = 1'b1; oe0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr0 = 4'(i); drv0 = wtab[i];
            step();
            model0[i] = wtab[i];
        end

        // Read back, one cycle latency.
        den0 = 1'b0; we0 = 1'b0; oe0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr0 = 4'(i);
            exp_q.push_back(model0[i]);
            step();
            check_sb($sformatf("read_a%0d", i), bus0);
        end

        // Deselected write must not land; read register holds through it.
        den0 = 1'b1; drv0 = 16'hFFFF; cs0 = 1'b0; we0 = 1'b1; addr0 = 4'd3;
        step();
        den0 = 1'b0;
        #1;
        check("cs_low_write_hiz", bus0, HIZ);
        cs0 = 1'b1; we0 = 1'b0; oe0 = 1'b1;
        #1;
        check("hold_no_read", bus0, model0[15]);
        exp_q.push_back(model0[3]);
        step();
        check_sb("cs_low_write_ignored", bus0);

        // oe gating is combinational.
        oe0 = 1'b0; addr0 = 4'd2;
        step();
        check("oe_low_hiz", bus0, HIZ);
        oe0 = 1'b1;
        #1;
        check("oe_rise_same_cycle", bus0, model0[2]);

        // Write with oe high: DUT stays off the bus, then read-after-write.
        den0 = 1'b1; drv0 = 16'hA5A5; we0 = 1'b1; addr0 = 4'd5;
        #1;
        check("write_oe_no_contend", bus0, 16'hA5A5);
        step();
        model0[5] = 16'hA5A5;
        den0 = 1'b0; we0 = 1'b0;
        exp_q.push_back(model0[5]);
        step();
        check_sb("read_after_write", bus0);

        // DEPTH=12 instance: out-of-range write ignored, read returns zero.
        den1 = 1'b1; cs1 = 1'b1; we1 = 1'b1; oe1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            addr1 = 4'(i); drv1 = wtab[i] ^ 16'h0F0F;
            step();
            model1[i] = wtab[i] ^ 16'h0F0F;
        end
        addr1 = 4'd13; drv1 = 16'h1234;
        step();
        den1 = 1'b0; we1 = 1'b0; oe1 = 1'b1; addr1 = 4'd0;
        exp_q.push_back(model1[0]);
        step();
        check_sb("d12_read_a0", bus1);
        addr1 = 4'd13;
        exp_q.push_back(16'h0000);
        step();
        check_sb("d12_read_oob", bus1);
        for (int i = 1; i < 12; i++) begin
            addr1 = 4'(i);
            exp_q.push_back(model1[i]);
            step();
            check_sb($sformatf("d12_read_a%0d", i), bus1);
        end
        cs1 = 1'b0;

        // Reset mid-sequence: coinciding write discarded, register cleared.
        den0 = 1'b1; drv0 = 16'hBEEF; we0 = 1'b1; oe0 = 1'b0; addr0 = 4'd7;
        step();
        model0[7] = 16'hBEEF;
        rst = 1'b1; drv0 = 16'h1111;
        step();
        rst = 1'b0; den0 = 1'b0; we0 = 1'b0; oe0 = 1'b1;
        #1;
        check("post_reset_reg", bus0, 16'h0000);
`ifdef SINGLE_PORT_RAM_INIT_CLEAR_EN
        for (int i = 0; i < 16; i++) model0[i] = 16'h0000;
`endif
        exp_q.push_back(model0[7]);
        step();
        check_sb("post_reset_a7", bus0);
        addr0 = 4'd0;
        exp_q.push_back(model0[0]);
        step();
        check_sb("post_reset_a0", bus0);
        cs0 = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
